// File: rtl/ram_master.sv
// ram_master
//
// Initiator-side controller that drives a block RAM with separate read and
// write ports on behalf of the CPU core. It accepts load, store and
// block-copy commands over a valid/ready request channel. It sequences the
// RAM ports around the RAM's one-cycle registered read latency. It returns
// one response per command over a valid/ready response channel.
//
// Ports
//   clk, rst        system clock and synchronous active-high reset
//   req_valid/ready request handshake (ready only while idle)
//   req_op          00 load, 01 store, 10 copy, 11 reserved (flags rsp_err)
//   req_addr        load/store address, or copy source base
//   req_addr2       copy destination base
//   req_len         copy byte count (0 is a legal no-op copy)
//   req_wdata       store data
//   rsp_valid/ready response handshake
//   rsp_rdata       load data, store echo, or copy byte count
//   rsp_err         set for the reserved opcode
//   ram_*           RAM read/write address, data and enables
//   ram_data_rd     registered RAM read data (valid the cycle after ram_rd_en)
//   busy            high whenever the controller is not idle

module ram_master #(
    parameter int BUS_WIDTH  = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [BUS_WIDTH-1:0]  req_addr,
    input  logic [BUS_WIDTH-1:0]  req_addr2,
    input  logic [BUS_WIDTH-1:0]  req_len,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [BUS_WIDTH-1:0]  ram_addr_rd,
    output logic [BUS_WIDTH-1:0]  ram_addr_wr,
    output logic [DATA_WIDTH-1:0] ram_data_wr,
    output logic                  ram_rd_en,
    output logic                  ram_wr_en,
    input  logic [DATA_WIDTH-1:0] ram_data_rd,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_CAP,
        WR,
        CP_RD,
        CP_WR,
        RESP
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;

    state_t                state_q, state_d;
    logic [BUS_WIDTH-1:0]  addr_q, addr_d;
    logic [BUS_WIDTH-1:0]  addr2_q, addr2_d;
    logic [BUS_WIDTH-1:0]  len_q, len_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BUS_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  ready_q, ready_d;

    logic [BUS_WIDTH-1:0]  idxInc;

    assign idxInc = idx_q + BUS_WIDTH'(1);

    // State and datapath registers. req_ready is registered so that it stays
    // low in the reset cycle and rises only in the first cycle after rst has
    // been sampled low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            addr2_q <= '0;
            len_q   <= '0;
            wdata_q <= '0;
            idx_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            addr2_q <= addr2_d;
            len_q   <= len_d;
            wdata_q <= wdata_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    // Next-state logic. All request fields are captured on acceptance so the
    // RAM side depends only on registered state. A copy walks the index from
    // zero and returns to CP_RD until the incremented index reaches the length.
    // Because the index is BUS_WIDTH wide, the longest copy is 2^BUS_WIDTH-1
    // bytes.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        addr2_d = addr2_q;
        len_d   = len_q;
        wdata_d = wdata_q;
        idx_d   = idx_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    addr_d  = req_addr;
                    addr2_d = req_addr2;
                    len_d   = req_len;
                    wdata_d = req_wdata;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    rdata_d = '0;
                    case (req_op)
                        OP_LOAD: state_d = RD;
                        OP_STORE: begin
                            state_d = WR;
                            rdata_d = req_wdata;
                        end
                        OP_COPY: begin
                            if (req_len == '0) begin
                                state_d = RESP;
                            end else begin
                                state_d = CP_RD;
                                rdata_d = DATA_WIDTH'(req_len);
                            end
                        end
                        default: begin
                            state_d = RESP;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            RD:     state_d = RD_CAP;
            RD_CAP: begin
                rdata_d = ram_data_rd;
                state_d = RESP;
            end
            WR:     state_d = RESP;
            CP_RD:  state_d = CP_WR;
            CP_WR: begin
                idx_d   = idxInc;
                state_d = (idxInc == len_q) ? RESP : CP_RD;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready_d = (state_d == IDLE);

    // RAM port decode. The read and write enables come from mutually
    // exclusive states, so they can never be high together. During a copy,
    // the write data is the RAM read data returned from the previous CP_RD
    // cycle.
    always_comb begin
        ram_rd_en   = 1'b0;
        ram_wr_en   = 1'b0;
        ram_addr_rd = '0;
        ram_addr_wr = '0;
        ram_data_wr = '0;
        case (state_q)
            RD: begin
                ram_rd_en   = 1'b1;
                ram_addr_rd = addr_q;
            end
            CP_RD: begin
                ram_rd_en   = 1'b1;
                ram_addr_rd = addr_q + idx_q;
            end
            WR: begin
                ram_wr_en   = 1'b1;
                ram_addr_wr = addr_q;
                ram_data_wr = wdata_q;
            end
            CP_WR: begin
                ram_wr_en   = 1'b1;
                ram_addr_wr = addr2_q + idx_q;
                ram_data_wr = ram_data_rd;
            end
            default: begin
                ram_rd_en = 1'b0;
            end
        endcase
    end

    assign req_ready = ready_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_master.sv
// tb_ram_master
//
// Testbench for ram_master. A behavioural RAM model provides registered
// reads that hold their value while ram_rd_en is low. Each command pushes
// its expected response onto a scoreboard queue. The entry holds the
// expected data, the error flag and the latency from acceptance to the first
// rsp_valid. A negedge monitor pops the queue on every response transfer
// and compares the entry against the response. Memory contents, reset
// behaviour and stall stability are checked directly against hand-computed
// constants.

module tb_ram_master;

    localparam int BW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          reqValid;
    logic          reqReady;
    logic [1:0]    reqOp;
    logic [BW-1:0] reqAddr;
    logic [BW-1:0] reqAddr2;
    logic [BW-1:0] reqLen;
    logic [DW-1:0] reqWdata;
    logic          rspValid;
    logic          rspReady;
    logic [DW-1:0] rspRdata;
    logic          rspErr;
    logic [BW-1:0] ramAddrRd;
    logic [BW-1:0] ramAddrWr;
    logic [DW-1:0] ramDataWr;
    logic          ramRdEn;
    logic          ramWrEn;
    logic [DW-1:0] ramDataRd = '0;
    logic          busy;

    logic [DW-1:0] mem [0:(1<<BW)-1];

    typedef struct {
        int rdata;
        int err;
        int lat;
        int acc;
    } exp_t;

    exp_t sbQ[$];

    int cyc        = 0;
    int checks     = 0;
    int failures   = 0;
    int bothHigh   = 0;
    int enCount    = 0;
    int firstValid = -1;
    int heldRdata  = 0;
    int heldErr    = 0;

    ram_master #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (reqValid),
        .req_ready   (reqReady),
        .req_op      (reqOp),
        .req_addr    (reqAddr),
        .req_addr2   (reqAddr2),
        .req_len     (reqLen),
        .req_wdata   (reqWdata),
        .rsp_valid   (rspValid),
        .rsp_ready   (rspReady),
        .rsp_rdata   (rspRdata),
        .rsp_err     (rspErr),
        .ram_addr_rd (ramAddrRd),
        .ram_addr_wr (ramAddrWr),
        .ram_data_wr (ramDataWr),
        .ram_rd_en   (ramRdEn),
        .ram_wr_en   (ramWrEn),
        .ram_data_rd (ramDataRd),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM model: registered read data holds while ram_rd_en is low.
    always @(posedge clk) begin
        if (ramWrEn) mem[ramAddrWr] <= ramDataWr;
        if (ramRdEn) ramDataRd <= mem[ramAddrRd];
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor and scoreboard. It also tracks RAM enable activity.
    always @(negedge clk) begin
        if (ramRdEn && ramWrEn) bothHigh++;
        if (ramRdEn || ramWrEn) enCount++;
        if (!rst && rspValid) begin
            if (firstValid < 0) begin
                firstValid = cyc;
            end else begin
                checkOutput("hold_rdata", int'(rspRdata), heldRdata);
                checkOutput("hold_err", int'(rspErr), heldErr);
            end
            heldRdata = int'(rspRdata);
            heldErr   = int'(rspErr);
            if (rspReady) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_rsp: got rdata 0x%0h with no response expected", rspRdata);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput("rsp_rdata", int'(rspRdata), e.rdata);
                    checkOutput("rsp_err", int'(rspErr), e.err);
                    checkOutput("rsp_latency", firstValid - e.acc, e.lat);
                end
                firstValid = -1;
            end
        end else begin
            firstValid = -1;
        end
    end

    // Issue one request and, if a response is expected, queue it on the scoreboard.
    task automatic applyStimulus(input logic [1:0] op, input logic [BW-1:0] addr,
                                 input logic [BW-1:0] addr2, input logic [BW-1:0] len,
                                 input logic [DW-1:0] wdata, input bit expectRsp,
                                 input int expRdata, input int expErr, input int expLat,
                                 output int acc);
        bit accepted;
        accepted = 1'b0;
        acc      = -1;
        @(posedge clk);
        #1;
        reqOp    = op;
        reqAddr  = addr;
        reqAddr2 = addr2;
        reqLen   = len;
        reqWdata = wdata;
        reqValid = 1'b1;
        for (int k = 0; k < 50 && !accepted; k++) begin
            @(negedge clk);
            if (reqReady) begin
                accepted = 1'b1;
                acc      = cyc;
                if (expectRsp) sbQ.push_back('{expRdata, expErr, expLat, cyc});
            end
        end
        if (!accepted) begin
            checks++;
            failures++;
            $display("[TB] FAIL req_accept: got req_ready 0 for 50 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        reqValid = 1'b0;
    endtask

    task automatic waitDrain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (sbQ.size() == 0 && !busy && reqReady) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout: got %0d pending responses, expected 0", sbQ.size());
        end
    endtask

    initial begin
        int acc;
        int enSnap;
        bit seen;
        for (int i = 0; i < (1 << BW); i++) mem[i] = '0;
        rst      = 1'b1;
        reqValid = 1'b0;
        reqOp    = '0;
        reqAddr  = '0;
        reqAddr2 = '0;
        reqLen   = '0;
        reqWdata = '0;
        rspReady = 1'b1;

        // Reset state: every output low.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_ready", int'(reqReady), 0);
        checkOutput("rst_rsp_valid", int'(rspValid), 0);
        checkOutput("rst_rsp_err", int'(rspErr), 0);
        checkOutput("rst_rsp_rdata", int'(rspRdata), 0);
        checkOutput("rst_ram_rd_en", int'(ramRdEn), 0);
        checkOutput("rst_ram_wr_en", int'(ramWrEn), 0);
        checkOutput("rst_ram_addr_rd", int'(ramAddrRd), 0);
        checkOutput("rst_ram_addr_wr", int'(ramAddrWr), 0);
        checkOutput("rst_ram_data_wr", int'(ramDataWr), 0);
        checkOutput("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst_first", int'(reqReady), 0);
        @(negedge clk);
        checkOutput("ready_after_rst_second", int'(reqReady), 1);

        // Store then load.
        applyStimulus(2'b01, 8'h03, 8'h00, 8'h00, 8'hA5, 1'b1, 'hA5, 0, 2, acc);
        waitDrain();
        checkOutput("mem_03", int'(mem[8'h03]), 'hA5);
        applyStimulus(2'b00, 8'h03, 8'h00, 8'h00, 8'h00, 1'b1, 'hA5, 0, 3, acc);
        waitDrain();

        // Copy of four bytes.
        mem[8'h00] = 8'h11;
        mem[8'h01] = 8'h22;
        mem[8'h02] = 8'h33;
        mem[8'h03] = 8'h44;
        applyStimulus(2'b10, 8'h00, 8'h10, 8'h04, 8'h00, 1'b1, 'h04, 0, 9, acc);
        waitDrain();
        checkOutput("mem_10", int'(mem[8'h10]), 'h11);
        checkOutput("mem_11", int'(mem[8'h11]), 'h22);
        checkOutput("mem_12", int'(mem[8'h12]), 'h33);
        checkOutput("mem_13", int'(mem[8'h13]), 'h44);

        // Copy whose source address wraps past the top of memory.
        mem[8'hFE] = 8'h61;
        mem[8'hFF] = 8'h62;
        applyStimulus(2'b10, 8'hFE, 8'h20, 8'h03, 8'h00, 1'b1, 'h03, 0, 7, acc);
        waitDrain();
        checkOutput("mem_20", int'(mem[8'h20]), 'h61);
        checkOutput("mem_21", int'(mem[8'h21]), 'h62);
        checkOutput("mem_22", int'(mem[8'h22]), 'h11);

        // Zero-length copy: immediate response, no RAM activity.
        enSnap = enCount;
        applyStimulus(2'b10, 8'h05, 8'h60, 8'h00, 8'h00, 1'b1, 'h00, 0, 1, acc);
        waitDrain();
        checkOutput("len0_ram_enables", enCount - enSnap, 0);

        // Load with the response stalled.
        rspReady = 1'b0;
        applyStimulus(2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 'h11, 0, 3, acc);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (rspValid) seen = 1'b1;
        end
        checkOutput("stall_rsp_seen", int'(seen), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("stall_rsp_valid", int'(rspValid), 1);
            checkOutput("stall_rsp_rdata", int'(rspRdata), 'h11);
            checkOutput("stall_req_ready", int'(reqReady), 0);
            checkOutput("stall_busy", int'(busy), 1);
        end
        @(posedge clk);
        #1;
        rspReady = 1'b1;
        waitDrain();
        checkOutput("stall_idle_busy", int'(busy), 0);

        // Reserved opcode: error response, then a clean response.
        enSnap = enCount;
        applyStimulus(2'b11, 8'h07, 8'h08, 8'h09, 8'h5C, 1'b1, 'h00, 1, 1, acc);
        waitDrain();
        checkOutput("reserved_ram_enables", enCount - enSnap, 0);
        applyStimulus(2'b01, 8'h30, 8'h00, 8'h00, 8'h77, 1'b1, 'h77, 0, 2, acc);
        waitDrain();

        // Reset in the middle of a copy, after two bytes have been written.
        mem[8'h40] = 8'hAA;
        mem[8'h41] = 8'hBB;
        mem[8'h42] = 8'hCC;
        mem[8'h43] = 8'hDD;
        applyStimulus(2'b10, 8'h40, 8'h50, 8'h04, 8'h00, 1'b0, 0, 0, 0, acc);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_req_ready_low", int'(reqReady), 0);
        checkOutput("abort_busy", int'(busy), 0);
        @(negedge clk);
        checkOutput("abort_req_ready_high", int'(reqReady), 1);
        repeat (5) @(negedge clk);
        checkOutput("abort_mem_50", int'(mem[8'h50]), 'hAA);
        checkOutput("abort_mem_51", int'(mem[8'h51]), 'hBB);
        checkOutput("abort_mem_52", int'(mem[8'h52]), 'h00);
        checkOutput("abort_mem_53", int'(mem[8'h53]), 'h00);

        checkOutput("rd_wr_both_high", bothHigh, 0);
        checkOutput("scoreboard_empty", sbQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
